// File: rtl/k6502_seq_pkg.sv
// Shared constants for the k6502 instruction sequencer: cycle encodings,
// sequence codes and datapath widths.
package k6502_seq_pkg;

  localparam int IR_W  = 8;
  localparam int CYC_W = 6;

  localparam logic [IR_W-1:0] BRK_DEFAULT = 8'h00;

  // One-hot execute cycles; the all-zero vector is the opcode fetch cycle.
  localparam logic [CYC_W-1:0] C_N = 6'b000000;
  localparam logic [CYC_W-1:0] C_0 = 6'b000001;
  localparam logic [CYC_W-1:0] C_1 = 6'b000010;
  localparam logic [CYC_W-1:0] C_2 = 6'b000100;
  localparam logic [CYC_W-1:0] C_3 = 6'b001000;
  localparam logic [CYC_W-1:0] C_4 = 6'b010000;
  localparam logic [CYC_W-1:0] C_5 = 6'b100000;

  typedef enum logic [2:0] {
    SEQ_NON = 3'b000,
    SEQ_IRQ = 3'b001,
    SEQ_NMI = 3'b010,
    SEQ_RST = 3'b100
  } seq_e;

endpackage

// File: rtl/k6502_pin_sync.sv
// Multi-stage synchroniser for an asynchronous active-low pin, with a
// falling-edge strobe taken from the synchronised level.
module k6502_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_n,
  output logic o_level_n,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Flops come out of reset high so an idle pin never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], pin_n};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level_n = r_sync[STAGES-1];
  assign o_fall    = r_prev & ~r_sync[STAGES-1];

endmodule

// File: rtl/k6502_seq.sv
// k6502 instruction sequencer: IR latch, one-hot cycle counter, reset start-up
// and NMI/IRQ arbitration feeding the microcode ROM lookup key.
module k6502_seq
  import k6502_seq_pkg::*;
#(
  parameter int              SYNC_STAGES = 2,
  parameter logic [IR_W-1:0] BRK_OPCODE  = BRK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic [IR_W-1:0]  data_in,
  input  logic             sync,
  input  logic             i_flag,
  input  logic             nmi_n,
  input  logic             irq_n,
  output logic [IR_W-1:0]  ir,
  output logic [CYC_W-1:0] cycle,
  output logic             mc_rst,
  output logic             mc_nmi,
  output logic             mc_irq,
  output logic             fetch,
  output logic             seq_err
);

  logic [IR_W-1:0]  r_ir,    w_ir_nxt;
  logic [CYC_W-1:0] r_cycle, w_cyc_nxt;
  seq_e             r_seq,   w_seq_nxt;
  logic             r_err,   w_err_nxt;
  logic             r_nmi_pend, w_nmi_pend_nxt;
  logic             w_nmi_take;

  logic w_nmi_level_n_unused, w_nmi_fall;
  logic w_irq_level_n, w_irq_fall_unused;
  logic w_irq_s;

  k6502_pin_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin_n    (nmi_n),
    .o_level_n(w_nmi_level_n_unused),
    .o_fall   (w_nmi_fall)
  );

  k6502_pin_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin_n    (irq_n),
    .o_level_n(w_irq_level_n),
    .o_fall   (w_irq_fall_unused)
  );

  assign w_irq_s = ~w_irq_level_n;

  always_comb begin
    w_ir_nxt   = r_ir;
    w_cyc_nxt  = r_cycle;
    w_seq_nxt  = r_seq;
    w_err_nxt  = 1'b0;
    w_nmi_take = 1'b0;
    if (rdy) begin
      if (r_cycle == C_N) begin
        w_ir_nxt  = data_in;
        w_cyc_nxt = C_0;
      end else if (!sync) begin
        if (r_cycle == C_5) begin
          w_cyc_nxt = C_N;
          w_err_nxt = 1'b1;
          w_seq_nxt = SEQ_NON;
        end else begin
          w_cyc_nxt = r_cycle << 1;
        end
      end else begin
        w_seq_nxt = SEQ_NON;
        w_cyc_nxt = C_N;
        // The reset sequence always falls through to a plain opcode fetch.
        if (r_seq != SEQ_RST) begin
          if (r_nmi_pend) begin
            w_seq_nxt  = SEQ_NMI;
            w_nmi_take = 1'b1;
            w_ir_nxt   = BRK_OPCODE;
            w_cyc_nxt  = C_0;
          end else if (w_irq_s && !i_flag) begin
            w_seq_nxt = SEQ_IRQ;
            w_ir_nxt  = BRK_OPCODE;
            w_cyc_nxt = C_0;
          end
        end
      end
    end
  end

  // Edge capture ignores rdy; a new edge outranks the clear from being serviced.
  always_comb begin
    w_nmi_pend_nxt = r_nmi_pend;
    if (r_seq == SEQ_RST)
      w_nmi_pend_nxt = 1'b0;
    else if (w_nmi_fall)
      w_nmi_pend_nxt = 1'b1;
    else if (w_nmi_take)
      w_nmi_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= BRK_OPCODE;
      r_cycle    <= C_0;
      r_seq      <= SEQ_RST;
      r_err      <= 1'b0;
      r_nmi_pend <= 1'b0;
    end else begin
      r_ir       <= w_ir_nxt;
      r_cycle    <= w_cyc_nxt;
      r_seq      <= w_seq_nxt;
      r_err      <= w_err_nxt;
      r_nmi_pend <= w_nmi_pend_nxt;
    end
  end

  assign ir      = r_ir;
  assign cycle   = r_cycle;
  assign mc_rst  = (r_seq == SEQ_RST);
  assign mc_nmi  = (r_seq == SEQ_NMI);
  assign mc_irq  = (r_seq == SEQ_IRQ);
  assign fetch   = (r_cycle == C_N);
  assign seq_err = r_err;

endmodule

// File: tb/tb_k6502_seq.sv
// Directed scoreboard bench for the k6502 sequencer: each clocked step queues
// the expected post-edge state and checks it on the following falling edge.
module tb_k6502_seq;

  logic       clk = 1'b0;
  logic       rst_n, rdy, sync, i_flag, nmi_n, irq_n;
  logic [7:0] data_in;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       mc_rst, mc_nmi, mc_irq, fetch, seq_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] M_NON = 3'b000;
  localparam logic [2:0] M_IRQ = 3'b001;
  localparam logic [2:0] M_NMI = 3'b010;
  localparam logic [2:0] M_RST = 3'b100;

  typedef struct {
    string      tag;
    logic [7:0] ir;
    logic [5:0] cyc;
    logic [2:0] mc;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  k6502_seq #(.SYNC_STAGES(2), .BRK_OPCODE(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rdy    (rdy),
    .data_in(data_in),
    .sync   (sync),
    .i_flag (i_flag),
    .nmi_n  (nmi_n),
    .irq_n  (irq_n),
    .ir     (ir),
    .cycle  (cycle),
    .mc_rst (mc_rst),
    .mc_nmi (mc_nmi),
    .mc_irq (mc_irq),
    .fetch  (fetch),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_ir, input logic [5:0] e_cyc,
                           input logic [2:0] e_mc, input logic e_err);
    chk_eq({tag, ".cycle"}, cycle, e_cyc);
    chk_eq({tag, ".ir"}, ir, e_ir);
    chk_eq({tag, ".mc"}, {mc_rst, mc_nmi, mc_irq}, e_mc);
    chk_eq({tag, ".err"}, seq_err, e_err);
    chk_eq({tag, ".fetch"}, fetch, (e_cyc == 6'd0));
  endtask

  task automatic step(input string tag, input logic [7:0] e_ir, input logic [5:0] e_cyc,
                      input logic [2:0] e_mc, input logic e_err);
    exp_t e;
    e.tag = tag; e.ir = e_ir; e.cyc = e_cyc; e.mc = e_mc; e.err = e_err;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk_state(e.tag, e.ir, e.cyc, e.mc, e.err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; rdy = 1'b1; data_in = 8'h00; sync = 1'b0;
    i_flag = 1'b1; nmi_n = 1'b1; irq_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_state("reset", 8'h00, 6'h01, M_RST, 1'b0);
    repeat (2) @(negedge clk);
    chk_state("reset_held", 8'h00, 6'h01, M_RST, 1'b0);
    rst_n = 1'b1;

    // Reset start-up sequence
    step("rst_c1", 8'h00, 6'h02, M_RST, 1'b0);
    step("rst_c2", 8'h00, 6'h04, M_RST, 1'b0);
    step("rst_c3", 8'h00, 6'h08, M_RST, 1'b0);
    step("rst_c4", 8'h00, 6'h10, M_RST, 1'b0);
    sync = 1'b1;
    step("rst_end", 8'h00, 6'h00, M_NON, 1'b0);

    // LDA immediate; sync is held high through fetch, where it must be ignored
    data_in = 8'hA9;
    step("lda_fetch", 8'hA9, 6'h01, M_NON, 1'b0);
    step("lda_end", 8'hA9, 6'h00, M_NON, 1'b0);

    // NMI during an absolute instruction, then a chained NMI
    data_in = 8'hAD; sync = 1'b0;
    step("abs_fetch", 8'hAD, 6'h01, M_NON, 1'b0);
    nmi_n = 1'b0;
    step("abs_c1", 8'hAD, 6'h02, M_NON, 1'b0);
    step("abs_c2", 8'hAD, 6'h04, M_NON, 1'b0);
    step("abs_c3", 8'hAD, 6'h08, M_NON, 1'b0);
    sync = 1'b1; nmi_n = 1'b1;
    step("nmi_take", 8'h00, 6'h01, M_NMI, 1'b0);
    nmi_n = 1'b0; sync = 1'b0;
    step("nmi_c1", 8'h00, 6'h02, M_NMI, 1'b0);
    step("nmi_c2", 8'h00, 6'h04, M_NMI, 1'b0);
    step("nmi_c3", 8'h00, 6'h08, M_NMI, 1'b0);
    sync = 1'b1;
    step("nmi_chain", 8'h00, 6'h01, M_NMI, 1'b0);
    step("nmi_end", 8'h00, 6'h00, M_NON, 1'b0);

    // IRQ masked by i_flag, then taken
    data_in = 8'hEA; irq_n = 1'b0; i_flag = 1'b1; sync = 1'b0;
    step("irqm_fetch", 8'hEA, 6'h01, M_NON, 1'b0);
    step("irqm_c1", 8'hEA, 6'h02, M_NON, 1'b0);
    sync = 1'b1;
    step("irqm_mask", 8'hEA, 6'h00, M_NON, 1'b0);
    sync = 1'b0;
    step("irq_fetch", 8'hEA, 6'h01, M_NON, 1'b0);
    sync = 1'b1; i_flag = 1'b0;
    step("irq_take", 8'h00, 6'h01, M_IRQ, 1'b0);
    i_flag = 1'b1;
    step("irq_end", 8'h00, 6'h00, M_NON, 1'b0);

    // NMI and IRQ both pending: NMI first, IRQ at the following boundary
    nmi_n = 1'b1; sync = 1'b0;
    step("both_fetch", 8'hEA, 6'h01, M_NON, 1'b0);
    nmi_n = 1'b0;
    step("both_c1", 8'hEA, 6'h02, M_NON, 1'b0);
    step("both_c2", 8'hEA, 6'h04, M_NON, 1'b0);
    step("both_c3", 8'hEA, 6'h08, M_NON, 1'b0);
    sync = 1'b1; i_flag = 1'b0;
    step("both_nmi", 8'h00, 6'h01, M_NMI, 1'b0);
    step("both_irq", 8'h00, 6'h01, M_IRQ, 1'b0);
    i_flag = 1'b1; irq_n = 1'b1;
    step("both_end", 8'h00, 6'h00, M_NON, 1'b0);

    // Stall with rdy low at C_2 while sync is high
    data_in = 8'h4C; sync = 1'b0;
    step("stall_fetch", 8'h4C, 6'h01, M_NON, 1'b0);
    step("stall_c1", 8'h4C, 6'h02, M_NON, 1'b0);
    step("stall_c2", 8'h4C, 6'h04, M_NON, 1'b0);
    rdy = 1'b0; sync = 1'b1; data_in = 8'hFF;
    for (int i = 0; i < 3; i++) step("stall_hold", 8'h4C, 6'h04, M_NON, 1'b0);
    rdy = 1'b1;
    step("stall_end", 8'h4C, 6'h00, M_NON, 1'b0);

    // Overrun past C_5 without sync
    data_in = 8'hEA; sync = 1'b0;
    step("ovr_fetch", 8'hEA, 6'h01, M_NON, 1'b0);
    for (int i = 1; i < 6; i++) step("ovr_run", 8'hEA, 6'd1 << i, M_NON, 1'b0);
    step("ovr_wrap", 8'hEA, 6'h00, M_NON, 1'b1);
    step("ovr_next", 8'hEA, 6'h01, M_NON, 1'b0);

    // IRQ sequence with an NMI edge pending, aborted by asynchronous reset at C_3
    irq_n = 1'b0; nmi_n = 1'b1;
    step("ar_c1", 8'hEA, 6'h02, M_NON, 1'b0);
    nmi_n = 1'b0;
    step("ar_c2", 8'hEA, 6'h04, M_NON, 1'b0);
    sync = 1'b1; i_flag = 1'b0;
    step("ar_irq", 8'h00, 6'h01, M_IRQ, 1'b0);
    sync = 1'b0; i_flag = 1'b1;
    step("ar_i1", 8'h00, 6'h02, M_IRQ, 1'b0);
    step("ar_i2", 8'h00, 6'h04, M_IRQ, 1'b0);
    step("ar_i3", 8'h00, 6'h08, M_IRQ, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_state("ar_async", 8'h00, 6'h01, M_RST, 1'b0);
    @(negedge clk);
    irq_n = 1'b1; nmi_n = 1'b1; rst_n = 1'b1;
    step("ar_rst1", 8'h00, 6'h02, M_RST, 1'b0);
    step("ar_rst2", 8'h00, 6'h04, M_RST, 1'b0);
    step("ar_rst3", 8'h00, 6'h08, M_RST, 1'b0);
    sync = 1'b1;
    step("ar_rst_end", 8'h00, 6'h00, M_NON, 1'b0);
    data_in = 8'hEA; sync = 1'b0;
    step("ar_fetch", 8'hEA, 6'h01, M_NON, 1'b0);
    sync = 1'b1;
    step("ar_no_pend", 8'hEA, 6'h00, M_NON, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/k6502_seq.md
Name: k6502_seq

Overview:
- Instruction sequencer for the k6502 core; sits directly upstream of the microcode ROM.
- Latches the opcode into IR and advances the one-hot cycle vector.
- Runs the reset start-up sequence, captures and prioritises NMI/IRQ, and drives the {rst,nmi,irq,ir,cycle} lookup key.
- Consumes the microcode SYNC/NEXT bit to end each sequence.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for the nmi_n/irq_n pins (minimum 2).
- BRK_OPCODE, 8'h00, opcode forced into IR for reset and interrupt sequences.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  1 = advance; 0 = hold all sequencer state
- data_in  in  8  data bus read value, used as the opcode in the fetch cycle
- sync  in  1  SYNC/NEXT bit from the microcode word: last cycle of the current sequence
- i_flag  in  1  P register interrupt-disable bit
- nmi_n  in  1  asynchronous NMI pin, falling-edge sensitive
- irq_n  in  1  asynchronous IRQ pin, low-level sensitive
- ir  out  8  instruction register
- cycle  out  6  one-hot cycle: C_N=000000 is the fetch cycle, C_0..C_5 = bit0..bit5
- mc_rst  out  1  reset sequence active
- mc_nmi  out  1  NMI sequence active
- mc_irq  out  1  IRQ sequence active
- fetch  out  1  combinational, equals (cycle==C_N)
- seq_err  out  1  one-cycle pulse: cycle overran C_5 without sync

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values, applied asynchronously on rst_n low:
  - ir=BRK_OPCODE, cycle=C_0, mc_rst=1, mc_nmi=0, mc_irq=0, seq_err=0.
  - nmi_pend=0; synchroniser flops=1 (pins idle high).
- At most one of mc_rst/mc_nmi/mc_irq is ever 1.
- All registered updates below are qualified by rdy=1. With rdy=0, ir, cycle, mc_* and seq_err hold (seq_err forced 0). The synchroniser and NMI edge capture keep running.
- Fetch cycle (cycle==C_N): ir<=data_in, cycle<=C_0. The sync input is ignored in this cycle.
- Execute cycle (cycle in C_0..C_5) with sync=0: cycle<=cycle<<1.
  - If cycle==C_5: cycle<=C_N, seq_err<=1 for one cycle, and mc_* are cleared.
- Execute cycle with sync=1 (boundary): clear mc_rst/mc_nmi/mc_irq, then choose the next sequence in priority order:
  1. nmi_pend=1 -> mc_nmi<=1, nmi_pend<=0, ir<=BRK_OPCODE, cycle<=C_0.
  2. Else irq_s=1 and i_flag=0 -> mc_irq<=1, ir<=BRK_OPCODE, cycle<=C_0.
  3. Else cycle<=C_N for a normal opcode fetch.
- Interrupt selection is evaluated at every boundary, including the end of an NMI/IRQ sequence. Back-to-back NMI chaining is therefore allowed.
- Boundary at the end of reset (mc_rst=1): the interrupt check is skipped and the next state is always C_N.
- nmi_pend:
  - Set when the synchronised nmi_n goes 1->0.
  - If a set and a clear occur in the same cycle, set wins.
  - Held at 0 while mc_rst=1; edges during reset are discarded.
- irq_s is the synchronised irq_n, inverted. It is level-sensitive and never latched; IRQ deasserted before the boundary is not serviced.
- Latency: a pin edge reaches nmi_pend after SYNC_STAGES+1 clocks.
- Reset asserted mid-instruction aborts immediately. Normal sequencing restarts from the reset sequence at C_0.

Decomposition:
- k6502_defs.v carries the shared constants:
  - cycle encodings C_N, C_0..C_5;
  - sequence codes RST=100, NMI=010, IRQ=001, NON=000;
  - BRK_OPCODE default;
  - widths for ir and cycle.
- One sub-module, k6502_pin_sync: a SYNC_STAGES-deep synchroniser plus falling-edge detect, instantiated once each for nmi_n and irq_n.
- All other logic is in k6502_seq.

Test Plan:
1. Reset sequence: release rst_n with rdy=1 and sync pulsed in the 5th cycle.
   - Required: cycle=01,02,04,08,10, mc_rst=1 throughout, then mc_rst=0, cycle=00, fetch=1.
2. LDA imm: fetch with data_in=A9 -> ir=A9, cycle=01; next cycle sync=1 -> cycle=00.
   - With nmi_n=1 and irq_n=1, no mc_* bit is set.
3. NMI: drop nmi_n during an AD instruction at C_1; sync arrives at C_3.
   - Required: next cycle mc_nmi=1, ir=00, cycle=01.
   - A second NMI edge during that sequence gives a chained mc_nmi=1 at its sync.
4. IRQ masking: irq_n=0 with i_flag=1 at the boundary -> cycle=00, mc_irq=0.
   - Same stimulus with i_flag=0 -> mc_irq=1, cycle=01.
   - NMI and IRQ both pending -> mc_nmi wins, and mc_irq follows at the next boundary.
5. Stall and overrun:
   - rdy=0 for 3 clocks at C_2 with sync=1 -> cycle stays 04, ir unchanged.
   - Never assert sync from C_0 -> after C_5, cycle=00 and seq_err pulses exactly 1 clock.
6. Async reset mid-operation: assert rst_n between clock edges at C_3 with mc_irq=1.
   - Required: outputs go to their reset values immediately.
   - A pending NMI edge captured before reset is gone after the reset sequence completes.
